// File: rtl/fetch_redirect_arbiter_pkg.sv
// Shared types for the IF-stage redirect arbiter: source encoding, pending
// entry layout, pending FSM states and the source priority rule.
package redirect_pkg;

  // Width of the target field carried in redirect_entry_t; the top-level XLEN must match it.
  localparam int unsigned REDIRECT_XLEN = 32;

  typedef enum logic [1:0] {
    SRC_TRAP   = 2'd0,
    SRC_MRET   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_PRED   = 2'd3
  } redirect_src_e;

  typedef struct packed {
    logic                     valid;
    redirect_src_e            src;
    logic [REDIRECT_XLEN-1:0] target;
  } redirect_entry_t;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_e;

  // Lower source code means higher priority.
  function automatic logic higher_priority(input redirect_src_e a, input redirect_src_e b);
    return (a < b);
  endfunction

endpackage

// File: rtl/fetch_redirect_arbiter_holdoff.sv
// Post-redirect BRAM holdoff down-counter: loads on issue, counts down on
// unstalled cycles, frozen while stalled; holdoff is asserted while nonzero.
module redirect_holdoff_counter #(
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_stall,
  output logic o_holdoff
);

  localparam logic [2:0] LOAD_VAL = 3'(HOLDOFF_CYCLES);

  logic [2:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge, independent of block order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= LOAD_VAL;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (!i_stall && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end
  end

  assign o_holdoff = (r_count != 3'd0);

endmodule

// File: rtl/fetch_redirect_arbiter.sv
// Arbitrates trap/mret/branch/prediction redirects into one PC redirect per
// cycle and buffers one while fetch is stalled. Optional statistics counters
// are enabled with FROST_REDIRECT_STATS_EN.
module fetch_redirect_arbiter
  import redirect_pkg::*;
#(
  parameter int unsigned XLEN           = REDIRECT_XLEN,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_trap_taken,
  input  logic            i_mret_taken,
  input  logic            i_branch_taken,
  input  logic            i_prediction_valid,
  input  logic [XLEN-1:0] i_trap_target,
  input  logic [XLEN-1:0] i_mret_target,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic [XLEN-1:0] i_predicted_target,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_target,
  output logic [1:0]      o_redirect_source,
  output logic            o_redirect_to_halfword,
  output logic            o_pending,
  output logic            o_holdoff
`ifdef FROST_REDIRECT_STATS_EN
  ,
  output logic [3:0][31:0] o_redirect_count,
  output logic [15:0]      o_overwrite_count
`endif
);

  pend_state_e     r_state;
  pend_state_e     w_next_state;
  redirect_src_e   r_pend_src;
  logic [XLEN-1:0] r_pend_target;

  redirect_entry_t w_incoming;
  redirect_entry_t w_pending;
  redirect_entry_t w_cand;
  logic            w_take_incoming;
  logic            w_pred_req;
  logic            w_issue;
  logic            w_capture;
  logic            w_overwrite;

  // Predictions are stale during holdoff and always lose to a resolved redirect.
  assign w_pred_req = i_prediction_valid & ~o_holdoff &
                      ~(i_trap_taken | i_mret_taken | i_branch_taken);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_incoming = '0;
    if (i_trap_taken) begin
      w_incoming = '{valid: 1'b1, src: SRC_TRAP, target: i_trap_target};
    end else if (i_mret_taken) begin
      w_incoming = '{valid: 1'b1, src: SRC_MRET, target: i_mret_target};
    end else if (i_branch_taken) begin
      w_incoming = '{valid: 1'b1, src: SRC_BRANCH, target: i_branch_target};
    end else if (w_pred_req) begin
      w_incoming = '{valid: 1'b1, src: SRC_PRED, target: i_predicted_target};
    end
  end

  // A flush discards the buffered entry in the same cycle it is asserted.
  always_comb begin
    w_pending.valid  = (r_state == PEND_FULL) & ~i_flush;
    w_pending.src    = r_pend_src;
    w_pending.target = r_pend_target;
  end

  // On equal source the incoming request wins, so only a strictly higher
  // priority pending entry survives.
  assign w_take_incoming = w_incoming.valid &
                           (~w_pending.valid | ~higher_priority(w_pending.src, w_incoming.src));

  always_comb begin
    w_cand = '0;
    if (w_take_incoming) begin
      w_cand = w_incoming;
    end else if (w_pending.valid) begin
      w_cand = w_pending;
    end
  end

  assign w_issue     = w_cand.valid & ~i_stall;
  assign w_capture   = w_cand.valid & i_stall;
  assign w_overwrite = w_capture & w_take_incoming & w_pending.valid;

  always_comb begin
    w_next_state = r_state;
    if (w_issue || i_flush) begin
      w_next_state = PEND_EMPTY;
    end
    if (w_capture) begin
      w_next_state = PEND_FULL;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= PEND_EMPTY;
      r_pend_src    <= SRC_TRAP;
      r_pend_target <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_pend_src    <= w_cand.src;
        r_pend_target <= w_cand.target;
      end
    end
  end

  redirect_holdoff_counter #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_issue),
    .i_stall  (i_stall),
    .o_holdoff(o_holdoff)
  );

  assign o_redirect_valid       = w_issue;
  assign o_redirect_target      = w_issue ? w_cand.target : '0;
  assign o_redirect_source      = w_issue ? w_cand.src : 2'd0;
  assign o_redirect_to_halfword = o_redirect_target[1];
  assign o_pending              = (r_state == PEND_FULL);

`ifdef FROST_REDIRECT_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_redirect_count  <= '0;
      o_overwrite_count <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_issue && (w_cand.src == 2'(i)) && (o_redirect_count[i] != '1)) begin
          o_redirect_count[i] <= o_redirect_count[i] + 32'd1;
        end
      end
      if (w_overwrite && (o_overwrite_count != '1)) begin
        o_overwrite_count <= o_overwrite_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// Directed self-checking bench for fetch_redirect_arbiter (HOLDOFF_CYCLES=2).
module tb_fetch_redirect_arbiter;

  logic        i_clk;
  logic        i_reset;
  logic        i_stall;
  logic        i_flush;
  logic        i_trap_taken;
  logic        i_mret_taken;
  logic        i_branch_taken;
  logic        i_prediction_valid;
  logic [31:0] i_trap_target;
  logic [31:0] i_mret_target;
  logic [31:0] i_branch_target;
  logic [31:0] i_predicted_target;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_target;
  logic [1:0]  o_redirect_source;
  logic        o_redirect_to_halfword;
  logic        o_pending;
  logic        o_holdoff;
`ifdef FROST_REDIRECT_STATS_EN
  logic [3:0][31:0] o_redirect_count;
  logic [15:0]      o_overwrite_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_redirect_arbiter #(
    .XLEN          (32),
    .HOLDOFF_CYCLES(2)
  ) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_stall               (i_stall),
    .i_flush               (i_flush),
    .i_trap_taken          (i_trap_taken),
    .i_mret_taken          (i_mret_taken),
    .i_branch_taken        (i_branch_taken),
    .i_prediction_valid    (i_prediction_valid),
    .i_trap_target         (i_trap_target),
    .i_mret_target         (i_mret_target),
    .i_branch_target       (i_branch_target),
    .i_predicted_target    (i_predicted_target),
    .o_redirect_valid      (o_redirect_valid),
    .o_redirect_target     (o_redirect_target),
    .o_redirect_source     (o_redirect_source),
    .o_redirect_to_halfword(o_redirect_to_halfword),
    .o_pending             (o_pending),
    .o_holdoff             (o_holdoff)
`ifdef FROST_REDIRECT_STATS_EN
    ,
    .o_redirect_count      (o_redirect_count),
    .o_overwrite_count     (o_overwrite_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic clear_req();
    i_flush            = 1'b0;
    i_trap_taken       = 1'b0;
    i_mret_taken       = 1'b0;
    i_branch_taken     = 1'b0;
    i_prediction_valid = 1'b0;
  endtask

  task automatic check_issue(input string name, input logic v, input logic [1:0] src,
                             input logic [31:0] tgt, input logic hw);
    tests_run++;
    if ({o_redirect_valid, o_redirect_source, o_redirect_target, o_redirect_to_halfword}
        !== {v, src, tgt, hw}) begin
      tests_failed++;
      $display("FAIL %s: got valid=%0b src=%0d target=%h half=%0b, expected valid=%0b src=%0d target=%h half=%0b",
               name, o_redirect_valid, o_redirect_source, o_redirect_target,
               o_redirect_to_halfword, v, src, tgt, hw);
    end
  endtask

  task automatic check_state(input string name, input logic pend, input logic hold);
    tests_run++;
    if ({o_pending, o_holdoff} !== {pend, hold}) begin
      tests_failed++;
      $display("FAIL %s: got pending=%0b holdoff=%0b, expected pending=%0b holdoff=%0b",
               name, o_pending, o_holdoff, pend, hold);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_stall = 1'b0;
    clear_req();
    i_trap_target = '0; i_mret_target = '0; i_branch_target = '0; i_predicted_target = '0;
    tick();
    tick();
    sample();
    check_state("reset_values", 1'b0, 1'b1);
    check_issue("reset_no_issue", 1'b0, 2'd0, 32'h0, 1'b0);
    tick();
    i_reset = 1'b0;
    sample();
    check_state("post_reset_c0", 1'b0, 1'b1);
    check_issue("post_reset_c0_idle", 1'b0, 2'd0, 32'h0, 1'b0);
    tick();
    sample();
    check_state("post_reset_c1", 1'b0, 1'b1);
    check_issue("post_reset_c1_idle", 1'b0, 2'd0, 32'h0, 1'b0);
    tick();
    sample();
    check_state("post_reset_c2", 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_same_cycle();
    i_branch_taken = 1'b1; i_branch_target = 32'h100;
    i_prediction_valid = 1'b1; i_predicted_target = 32'h200;
    sample();
    check_issue("branch_beats_pred", 1'b1, 2'd2, 32'h100, 1'b0);
    tick();
    clear_req();
    i_prediction_valid = 1'b1;
    sample();
    check_issue("pred_masked_in_holdoff", 1'b0, 2'd0, 32'h0, 1'b0);
    check_state("holdoff_after_issue_c1", 1'b0, 1'b1);
    tick();
    clear_req();
    sample();
    check_state("holdoff_after_issue_c2", 1'b0, 1'b1);
    tick();
    sample();
    check_state("holdoff_after_issue_done", 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_prediction();
    i_prediction_valid = 1'b1; i_predicted_target = 32'h206;
    sample();
    check_issue("pred_alone_halfword", 1'b1, 2'd3, 32'h206, 1'b1);
    tick();
    clear_req();
    tick();
    tick();
  endtask

  task automatic test_stall_capture();
    i_stall = 1'b1;
    i_branch_taken = 1'b1; i_branch_target = 32'h104;
    sample();
    check_issue("stall_no_issue", 1'b0, 2'd0, 32'h0, 1'b0);
    check_state("stall_c0_not_pending", 1'b0, 1'b0);
    tick();
    clear_req();
    i_trap_taken = 1'b1; i_trap_target = 32'h8000_0002;
    sample();
    check_state("stall_c1_pending", 1'b1, 1'b0);
    tick();
    clear_req();
    sample();
    check_state("stall_c2_pending", 1'b1, 1'b0);
    tick();
    i_stall = 1'b0;
    sample();
    check_issue("release_issues_trap", 1'b1, 2'd0, 32'h8000_0002, 1'b1);
    tick();
    sample();
    check_state("after_release", 1'b0, 1'b1);
    tick();
    tick();
  endtask

  task automatic test_no_overwrite();
    i_stall = 1'b1;
    i_trap_taken = 1'b1; i_trap_target = 32'h300;
    tick();
    clear_req();
    i_prediction_valid = 1'b1; i_predicted_target = 32'h400;
    sample();
    check_issue("stalled_pred_no_issue", 1'b0, 2'd0, 32'h0, 1'b0);
    tick();
    clear_req();
    tick();
    i_stall = 1'b0;
    sample();
    check_issue("trap_kept_over_pred", 1'b1, 2'd0, 32'h300, 1'b0);
    tick();
    sample();
    check_issue("pred_dropped", 1'b0, 2'd0, 32'h0, 1'b0);
    check_state("pending_cleared", 1'b0, 1'b1);
    tick();
    tick();
  endtask

  task automatic test_flush();
    i_stall = 1'b1;
    i_branch_taken = 1'b1; i_branch_target = 32'h500;
    tick();
    clear_req();
    i_flush = 1'b1;
    i_mret_taken = 1'b1; i_mret_target = 32'h40;
    tick();
    clear_req();
    sample();
    check_state("flush_capture_pending", 1'b1, 1'b0);
    tick();
    i_stall = 1'b0;
    sample();
    check_issue("flush_replaced_by_mret", 1'b1, 2'd1, 32'h40, 1'b0);
    tick();
    i_stall = 1'b1;
    i_branch_taken = 1'b1; i_branch_target = 32'h600;
    tick();
    clear_req();
    i_flush = 1'b1;
    tick();
    clear_req();
    i_stall = 1'b0;
    sample();
    check_issue("flush_discards_entry", 1'b0, 2'd0, 32'h0, 1'b0);
    check_state("flush_empty_holdoff_frozen", 1'b0, 1'b1);
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    i_branch_taken = 1'b1; i_branch_target = 32'h10;
    sample();
    check_issue("b2b_first", 1'b1, 2'd2, 32'h10, 1'b0);
    tick();
    clear_req();
    i_trap_taken = 1'b1; i_trap_target = 32'h20;
    sample();
    check_issue("b2b_second_in_holdoff", 1'b1, 2'd0, 32'h20, 1'b0);
    tick();
    clear_req();
    tick();
    sample();
    check_state("b2b_holdoff_reloaded", 1'b0, 1'b1);
    tick();
    sample();
    check_state("b2b_holdoff_done", 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_holdoff_freeze();
    i_branch_taken = 1'b1; i_branch_target = 32'h30;
    tick();
    clear_req();
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_state("freeze_stalled", 1'b0, 1'b1);
      tick();
    end
    i_stall = 1'b0;
    tick();
    sample();
    check_state("freeze_second_unstalled", 1'b0, 1'b1);
    tick();
    sample();
    check_state("freeze_done", 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    i_branch_taken = 1'b1; i_branch_target = 32'h50;
    tick();
    clear_req();
    i_stall = 1'b1;
    i_mret_taken = 1'b1; i_mret_target = 32'h60;
    tick();
    clear_req();
    #1;
    i_reset = 1'b1;
    #1;
    check_state("async_reset_clears_pending", 1'b0, 1'b1);
    tick();
    i_reset = 1'b0;
    i_stall = 1'b0;
    sample();
    check_issue("no_issue_after_reset", 1'b0, 2'd0, 32'h0, 1'b0);
    tick();
    tick();
    sample();
    check_state("reset_mid_holdoff_done", 1'b0, 1'b0);
    tick();
  endtask

`ifdef FROST_REDIRECT_STATS_EN
  task automatic test_stats();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tests_run++;
    if ({o_redirect_count, o_overwrite_count} !== '0) begin
      tests_failed++;
      $display("FAIL stats_reset: got counts=%h overwrite=%0d, expected all zero",
               o_redirect_count, o_overwrite_count);
    end
    i_branch_taken = 1'b1; i_branch_target = 32'h80;
    tick(); tick(); tick();
    clear_req();
    i_trap_taken = 1'b1; i_trap_target = 32'h90;
    tick();
    clear_req();
    i_stall = 1'b1;
    i_branch_taken = 1'b1; i_branch_target = 32'h70;
    tick();
    clear_req();
    i_trap_taken = 1'b1; i_trap_target = 32'h74;
    tick();
    clear_req();
    sample();
    tests_run++;
    if (o_redirect_count !== {32'd0, 32'd3, 32'd0, 32'd1}) begin
      tests_failed++;
      $display("FAIL stats_counts: got pred=%0d branch=%0d mret=%0d trap=%0d, expected 0 3 0 1",
               o_redirect_count[3], o_redirect_count[2], o_redirect_count[1], o_redirect_count[0]);
    end
    tests_run++;
    if (o_overwrite_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL stats_overwrite: got %0d, expected 1", o_overwrite_count);
    end
    tick();
    i_stall = 1'b0;
    tick();
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_same_cycle();
    test_prediction();
    test_stall_capture();
    test_no_overwrite();
    test_flush();
    test_back_to_back();
    test_holdoff_freeze();
    test_reset_mid();
`ifdef FROST_REDIRECT_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
